// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // MEM/WB bundle handed to writeback
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  err;
  } mem_wb_t;

  // r0 is hardwired, so a write to it is never enabled
  function automatic logic wr_en(input logic rw, input logic [4:0] rd);
    return rw & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: owns the IDLE/ACCESS state, the timeout
// counter, the registered request line and the combinational EX stall.
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,   // aligned memory op presented while idle
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic idle_o,
  output logic done_o,    // ack seen while accessing
  output logic tmo_o      // last allowed access cycle passed without ack
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;

  // Completion/abort decode; ack in the final cycle counts as completion
  always_comb begin
    idle_o  = (state_q == IDLE);
    done_o  = ~idle_o & ack_i;
    tmo_o   = ~idle_o & ~ack_i & (cnt_q == LAST);
    stall_o = idle_o ? start_i : ~(ack_i | tmo_o);
    req_o   = req_q;
  end

  // State, request and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_i) begin
            state_q <= ACCESS;
            req_q   <= 1'b1;
          end
        end
        ACCESS: begin
          if (ack_i || tmo_o) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: accepts the EX bundle, runs LDW/STW over a req/ack data-memory
// port, stalls EX while an access is outstanding and registers MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AW          = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_2_mem,
  input  logic [31:0]   alu_result_2_mem,
  input  logic [31:0]   addr_2_mem,
  input  logic [31:0]   st_data_2_mem,
  input  logic          mem_read_2_mem,
  input  logic          mem_write_2_mem,
  input  logic          mem_to_reg_2_mem,
  input  logic          reg_write_2_mem,
  input  logic [4:0]    rd_add_value_2_mem,
  output logic          stall_2_ex,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata,
  output logic [31:0]   wb_data_2_wb,
  output logic [4:0]    rd_add_value_2_wb,
  output logic          reg_write_2_wb,
  output logic [1:0]    err_2_wb
);

  logic mem_op, misaligned, start;
  logic fsm_idle, fsm_done, fsm_tmo;

  // Captured instruction for the duration of an access
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, alu_q;
  logic          we_q, rw_q, m2r_q;
  logic [4:0]    rd_q;

  mem_wb_t wb_d, wb_q;

  // Upper address bits are intentionally dropped by the word-address truncation
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_2_mem[31:AW+2];

  assign mem_op     = valid_2_mem & (mem_read_2_mem | mem_write_2_mem);
  assign misaligned = |addr_2_mem[1:0];
  assign start      = fsm_idle & mem_op & ~misaligned;

  mem_req_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .ack_i   (dmem_ack),
    .req_o   (dmem_req),
    .stall_o (stall_2_ex),
    .idle_o  (fsm_idle),
    .done_o  (fsm_done),
    .tmo_o   (fsm_tmo)
  );

  // Capture address/data/control when an access is launched
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rd_q    <= '0;
    end else if (start) begin
      addr_q  <= addr_2_mem[AW+1:2];
      wdata_q <= st_data_2_mem;
      alu_q   <= alu_result_2_mem;
      we_q    <= mem_write_2_mem;   // write wins when both are set
      rw_q    <= reg_write_2_mem;
      m2r_q   <= mem_to_reg_2_mem;
      rd_q    <= rd_add_value_2_mem;
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_we    = we_q;
  assign dmem_wdata = wdata_q;

  // WB bundle select: bubble unless an instruction retires this cycle
  always_comb begin
    wb_d.data      = alu_result_2_mem;
    wb_d.rd        = rd_add_value_2_mem;
    wb_d.reg_write = 1'b0;
    wb_d.err       = ERR_NONE;
    if (fsm_idle) begin
      if (valid_2_mem && !mem_op)
        wb_d.reg_write = wr_en(reg_write_2_mem, rd_add_value_2_mem);
      else if (mem_op && misaligned)
        wb_d.err = ERR_MISALIGN;
    end else if (fsm_done) begin
      wb_d.data      = m2r_q ? dmem_rdata : alu_q;
      wb_d.rd        = rd_q;
      wb_d.reg_write = ~we_q & wr_en(rw_q, rd_q);
    end else if (fsm_tmo) begin
      wb_d.data = alu_q;
      wb_d.rd   = rd_q;
      wb_d.err  = ERR_TIMEOUT;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign wb_data_2_wb      = wb_q.data;
  assign rd_add_value_2_wb = wb_q.rd;
  assign reg_write_2_wb    = wb_q.reg_write;
  assign err_2_wb          = wb_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load, store with wait
// states, misalign, timeout with stray ack, and reset during an access.
module tb_mem_stage;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_2_mem;
  logic [31:0]   alu_result_2_mem, addr_2_mem, st_data_2_mem;
  logic          mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem, reg_write_2_mem;
  logic [4:0]    rd_add_value_2_mem;
  logic          stall_2_ex, dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata, wb_data_2_wb;
  logic [4:0]    rd_add_value_2_wb;
  logic          reg_write_2_wb;
  logic [1:0]    err_2_wb;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.AW(AW), .TIMEOUT_CYC(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .valid_2_mem        (valid_2_mem),
    .alu_result_2_mem   (alu_result_2_mem),
    .addr_2_mem         (addr_2_mem),
    .st_data_2_mem      (st_data_2_mem),
    .mem_read_2_mem     (mem_read_2_mem),
    .mem_write_2_mem    (mem_write_2_mem),
    .mem_to_reg_2_mem   (mem_to_reg_2_mem),
    .reg_write_2_mem    (reg_write_2_mem),
    .rd_add_value_2_mem (rd_add_value_2_mem),
    .stall_2_ex         (stall_2_ex),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .wb_data_2_wb       (wb_data_2_wb),
    .rd_add_value_2_wb  (rd_add_value_2_wb),
    .reg_write_2_wb     (reg_write_2_wb),
    .err_2_wb           (err_2_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_2_mem = 0; mem_read_2_mem = 0; mem_write_2_mem = 0; mem_to_reg_2_mem = 0;
    reg_write_2_mem = 0; rd_add_value_2_mem = 0; alu_result_2_mem = 0;
    addr_2_mem = 0; st_data_2_mem = 0;
  endtask

  task automatic ldw(input logic [31:0] a, input logic [4:0] rd);
    valid_2_mem = 1; mem_read_2_mem = 1; mem_write_2_mem = 0; mem_to_reg_2_mem = 1;
    reg_write_2_mem = 1; rd_add_value_2_mem = rd; alu_result_2_mem = a;
    addr_2_mem = a; st_data_2_mem = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(dmem_req), 0);
    chk({tag, "_we"},    32'(dmem_we), 0);
    chk({tag, "_addr"},  32'(dmem_addr), 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wbd"},   wb_data_2_wb, 0);
    chk({tag, "_rd"},    32'(rd_add_value_2_wb), 0);
    chk({tag, "_rw"},    32'(reg_write_2_wb), 0);
    chk({tag, "_err"},   32'(err_2_wb), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1; dmem_ack = 0; dmem_rdata = 0;
    bubble();
    tick(); tick();
    chk_all_zero("rst");
    reset = 0;

    // 1: ALU op
    valid_2_mem = 1; alu_result_2_mem = 32'h5; reg_write_2_mem = 1; rd_add_value_2_mem = 3;
    #1 chk("alu_stall", 32'(stall_2_ex), 0);
    tick();
    chk("alu_wbd", wb_data_2_wb, 32'h5);
    chk("alu_rd",  32'(rd_add_value_2_wb), 3);
    chk("alu_rw",  32'(reg_write_2_wb), 1);
    // invalid cycle keeps reg_write low
    valid_2_mem = 0; alu_result_2_mem = 32'h9;
    tick();
    chk("inv_rw",  32'(reg_write_2_wb), 0);
    chk("inv_err", 32'(err_2_wb), 0);
    bubble();

    // 2: LDW, ack in first ACCESS cycle
    ldw(32'h40, 7);
    #1 chk("ld_stall_acc", 32'(stall_2_ex), 1);
    tick();
    chk("ld_req",  32'(dmem_req), 1);
    chk("ld_addr", 32'(dmem_addr), 32'h10);
    chk("ld_we",   32'(dmem_we), 0);
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_stall_ack", 32'(stall_2_ex), 0);
    tick();
    dmem_ack = 0; bubble();
    chk("ld_req_off", 32'(dmem_req), 0);
    chk("ld_wbd", wb_data_2_wb, 32'hDEAD_BEEF);
    chk("ld_rd",  32'(rd_add_value_2_wb), 7);
    chk("ld_rw",  32'(reg_write_2_wb), 1);
    chk("ld_err", 32'(err_2_wb), 0);

    // 3: STW, ack in the 4th ACCESS cycle
    valid_2_mem = 1; mem_write_2_mem = 1; addr_2_mem = 32'h44; st_data_2_mem = 32'h1234;
    #1 chk("st_stall_acc", 32'(stall_2_ex), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_req",   32'(dmem_req), 1);
      chk("st_we",    32'(dmem_we), 1);
      chk("st_addr",  32'(dmem_addr), 32'h11);
      chk("st_wdata", dmem_wdata, 32'h1234);
      dmem_ack = (i == 3);
      #1 chk("st_stall", 32'(stall_2_ex), (i == 3) ? 0 : 1);
      tick();
    end
    dmem_ack = 0; bubble();
    chk("st_req_off", 32'(dmem_req), 0);
    chk("st_rw",  32'(reg_write_2_wb), 0);
    chk("st_err", 32'(err_2_wb), 0);

    // 4: misaligned LDW
    ldw(32'h42, 5);
    #1 chk("mis_stall", 32'(stall_2_ex), 0);
    tick();
    bubble();
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_err", 32'(err_2_wb), 1);
    chk("mis_rw",  32'(reg_write_2_wb), 0);

    // 5: LDW never acked -> timeout after 16 ACCESS cycles
    ldw(32'h80, 9);
    #1 chk("to_stall_acc", 32'(stall_2_ex), 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(dmem_req), 1);
      #1 chk("to_stall", 32'(stall_2_ex), (i == 15) ? 0 : 1);
      tick();
    end
    bubble();
    chk("to_req_off", 32'(dmem_req), 0);
    chk("to_err", 32'(err_2_wb), 2);
    chk("to_rw",  32'(reg_write_2_wb), 0);
    dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;   // stray ack while idle
    tick();
    dmem_ack = 0;
    chk("stray_req", 32'(dmem_req), 0);
    chk("stray_err", 32'(err_2_wb), 0);
    chk("stray_rw",  32'(reg_write_2_wb), 0);

    // 6: reset mid-access, then normal load and an rd=0 ALU op
    ldw(32'h100, 4);
    tick();
    chk("rs_req", 32'(dmem_req), 1);
    bubble(); reset = 1;
    tick();
    chk_all_zero("rs");
    reset = 0; dmem_ack = 1;                    // late ack after reset
    tick();
    dmem_ack = 0;
    chk("rs_late_req", 32'(dmem_req), 0);
    chk("rs_late_rw",  32'(reg_write_2_wb), 0);
    ldw(32'h08, 2);
    tick();
    chk("rs_ld_req",  32'(dmem_req), 1);
    chk("rs_ld_addr", 32'(dmem_addr), 2);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 0; bubble();
    chk("rs_ld_wbd", wb_data_2_wb, 32'hCAFE_F00D);
    chk("rs_ld_rw",  32'(reg_write_2_wb), 1);
    chk("rs_ld_rd",  32'(rd_add_value_2_wb), 2);
    valid_2_mem = 1; alu_result_2_mem = 32'h77; reg_write_2_mem = 1; rd_add_value_2_mem = 0;
    tick();
    bubble();
    chk("r0_wbd", wb_data_2_wb, 32'h77);
    chk("r0_rw",  32'(reg_write_2_wb), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
